exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (legal: 8, 16, 32, 64).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation request is present.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 op  input  4  operation code: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 SLL, 6 SRL, 7 SRA, 8 MULTU, 9 DIVU, 10 MFHI, 11 MFLO; 12-15 reserved.
REQ-008 dataA  input  WIDTH  first operand (rs).
REQ-009 dataB  input  WIDTH  second operand (rt); also the shift source.
REQ-010 shamt  input  SHW  shift amount.
REQ-011 out_valid  output  1  result is valid this cycle (one-cycle pulse).
REQ-012 result  output  WIDTH  registered result.
REQ-013 busy  output  1  multi-cycle operation in progress.

Function
REQ-014 The unit SHALL accept a request on a rising edge where in_valid=1 and in_ready=1, and in_ready SHALL equal (state==IDLE).
REQ-015 The state machine SHALL have the states IDLE, MUL and DIV; busy SHALL be 1 in MUL and DIV.
REQ-016 Single-cycle ops (0-7, 10, 11) SHALL register result and pulse out_valid exactly 1 cycle after accept.
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH with no overflow flag; SLT SHALL compare signed and return 1 or 0.
REQ-018 SLL/SRL/SRA SHALL shift dataB by shamt; SRA SHALL replicate dataB[WIDTH-1].
REQ-019 Reserved ops SHALL be accepted, return result=0 with the normal out_valid pulse, and leave HI/LO unchanged.
REQ-020 MULTU SHALL enter MUL and perform an unsigned shift-add iteration, one bit per cycle, for WIDTH cycles.
REQ-021 On MULTU completion, HI SHALL receive product[2W-1:W], LO SHALL receive product[W-1:0], result SHALL equal LO, out_valid SHALL pulse, and the unit SHALL return to IDLE; accept-to-out_valid latency SHALL be WIDTH+1 cycles.
REQ-022 Operands SHALL be captured at accept, so later changes to dataA/dataB have no effect on the operation.
REQ-023 MFHI/MFLO SHALL return the current HI/LO values; because they cannot be issued while busy, they always see completed values.
REQ-024 out_valid SHALL never be asserted on two consecutive cycles for one request.
REQ-025 result SHALL hold its last value between out_valid pulses.

Reset
REQ-026 reset=0 SHALL asynchronously force state=IDLE, HI=0, LO=0, result=0, out_valid=0 and busy=0.
REQ-027 A reset asserted during MUL or DIV SHALL abort the operation with no out_valid pulse; in_ready SHALL be 1 on the first edge after reset release.

Configuration
REQ-028 The macro EXEC_UNIT_DIVU_EN SHALL control whether unsigned division is compiled in.
REQ-029 With EXEC_UNIT_DIVU_EN defined, DIVU SHALL enter DIV and run restoring division for WIDTH cycles, then set LO=quotient and HI=remainder, set result=LO and pulse out_valid; latency SHALL be WIDTH+1 cycles.
REQ-030 With EXEC_UNIT_DIVU_EN defined, a DIVU with dataB=0 SHALL still take WIDTH+1 cycles and SHALL produce LO=all ones and HI=dataA.
REQ-031 Without EXEC_UNIT_DIVU_EN, DIVU SHALL behave as a reserved op (REQ-019), and no DIV state or divider logic SHALL exist.

Verification
REQ-032 WIDTH=32, ADD 0xFFFFFFFF+1 -> out_valid 1 cycle later, result=0x00000000.
REQ-033 SLT dataA=0xFFFFFFFF, dataB=1 -> result=1; SRA dataB=0x80000000, shamt=4 -> result=0xF8000000.
REQ-034 MULTU 0xFFFFFFFF*0xFFFFFFFF -> in_ready low for 32 cycles, out_valid at cycle 33, then MFHI=0xFFFFFFFE and MFLO=0x00000001.
REQ-035 DIVU 100/7 with the macro defined -> LO=14, HI=2; DIVU 5/0 -> LO=0xFFFFFFFF, HI=5; without the macro, DIVU -> result=0 after 1 cycle.
REQ-036 Reset pulse at cycle 10 of a MULTU -> no out_valid pulse, then MFHI=0 and MFLO=0 after reset release.
REQ-037 WIDTH=8, MULTU 0xFF*0x02 -> latency 9 cycles, HI=0x01, LO=0xFE.

Source files
------------

// File: rtl/exec_unit.sv
// exec_unit: small integer execution unit with single-cycle ALU/shift ops and
// iterative MULTU/DIVU into HI/LO. Define EXEC_UNIT_DIVU_EN to build the divider.
module exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_SLT   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_MULTU = 4'd8,
    OP_DIVU  = 4'd9,
    OP_MFHI  = 4'd10,
    OP_MFLO  = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL
`ifdef EXEC_UNIT_DIVU_EN
    ,
    DIV
`endif
  } state_e;

  state_e           state, state_n;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] acc_hi;    // partial product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;    // multiplier being consumed / dividend-then-quotient
  logic [WIDTH-1:0] opnd;      // multiplicand / divisor, frozen at accept
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             start_mul;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign start_mul = accept && (op == OP_MULTU);

`ifdef EXEC_UNIT_DIVU_EN
  logic             start_div;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_n, div_quo_n;

  assign start_div = accept && (op == OP_DIVU);

  // Restoring step: bring in the next dividend bit, subtract if it fits.
  // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_rem_n = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_quo_n = {acc_lo[WIDTH-2:0], div_ge};
`endif

  // Shift-add step: add multiplicand on LSB of multiplier, then shift the pair right.
  assign mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    alu_res = '0;
    case (op)
      OP_AND:  alu_res = dataA & dataB;
      OP_OR:   alu_res = dataA | dataB;
      OP_ADD:  alu_res = dataA + dataB;
      OP_SUB:  alu_res = dataA - dataB;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
      OP_SLL:  alu_res = dataB << shamt;
      OP_SRL:  alu_res = dataB >> shamt;
      OP_SRA:  alu_res = $signed(dataB) >>> shamt;
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start_mul) state_n = MUL;
`ifdef EXEC_UNIT_DIVU_EN
        else if (start_div) state_n = DIV;
`endif
      end
      MUL: if (cnt == LAST) state_n = IDLE;
`ifdef EXEC_UNIT_DIVU_EN
      DIV: if (cnt == LAST) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi        <= '0;
      lo        <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      // NOTE: the iteration registers are reset as well; they are few flops and
      // this keeps X out of the datapath even though IDLE reloads them.
      acc_hi    <= '0;
      acc_lo    <= '0;
      opnd      <= '0;
      cnt       <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (op == OP_MULTU) begin
              acc_hi <= '0;
              acc_lo <= dataB;
              opnd   <= dataA;
            end
`ifdef EXEC_UNIT_DIVU_EN
            else if (op == OP_DIVU) begin
              acc_hi <= '0;
              acc_lo <= dataA;
              opnd   <= dataB;
            end
`endif
            else begin
              result    <= alu_res;
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_hi <= mul_hi_n;
          acc_lo <= mul_lo_n;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            hi        <= mul_hi_n;
            lo        <= mul_lo_n;
            result    <= mul_lo_n;
            out_valid <= 1'b1;
          end
        end
`ifdef EXEC_UNIT_DIVU_EN
        DIV: begin
          acc_hi <= div_rem_n;
          acc_lo <= div_quo_n;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            hi        <= div_rem_n;
            lo        <= div_quo_n;
            result    <= div_quo_n;
            out_valid <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit: a WIDTH=32 instance for the main
// vectors and a WIDTH=8 instance for the narrow multiply case.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [31:0] dataA = '0, dataB = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic [31:0] result;
  logic        busy;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [3:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [2:0]  sh8 = '0;
  logic        out_valid8;
  logic [7:0]  result8;
  logic        busy8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exec_unit #(.WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .dataA(dataA), .dataB(dataB), .shamt(shamt), .out_valid(out_valid),
    .result(result), .busy(busy)
  );

  exec_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .dataA(a8), .dataB(b8), .shamt(sh8), .out_valid(out_valid8),
    .result(result8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, scramble the operand inputs after accept, and count the
  // edges up to and including the one that raises out_valid.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic [31:0] res, output int lat,
                       output int rdy_low);
    @(negedge clk);
    in_valid = 1'b1; op = o; dataA = a; dataB = b; shamt = sh;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = 4'd0; dataA = 32'hDEADBEEF; dataB = 32'h13579BDF; shamt = 5'd3;
    lat = 1; rdy_low = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) rdy_low++;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic check_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh,
                          input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    int lat, rl;
    do_op(o, a, b, sh, res, lat, rl);
    check({tag, "/res"}, res, exp_res);
    check({tag, "/lat"}, lat, exp_lat);
  endtask

  task automatic do_op8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output int lat);
    @(negedge clk);
    in_valid8 = 1'b1; op8 = o; a8 = a; b8 = b;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3;
    lat = 1;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result8;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] res;
    logic [7:0]  res8;
    int lat, rl;
    int saw;

    // Reset state
    #12;
    check("rst/result", result, 32'h0);
    check("rst/out_valid", out_valid, 1'b0);
    check("rst/busy", busy, 1'b0);
    check("rst/in_ready", in_ready, 1'b1);
    @(negedge clk); reset = 1'b1;
    check_op("rst/mfhi", 4'd10, 32'h0, 32'h0, 5'd0, 32'h0, 1);
    check_op("rst/mflo", 4'd11, 32'h0, 32'h0, 5'd0, 32'h0, 1);

    // Single-cycle ops
    check_op("and", 4'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0, 1);
    check_op("or",  4'd1, 32'hF0000000, 32'h0000000F, 5'd0, 32'hF000000F, 1);
    check_op("add_wrap", 4'd2, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1);
    check_op("sub_wrap", 4'd3, 32'h00000000, 32'h00000001, 5'd0, 32'hFFFFFFFF, 1);
    check_op("slt_neg", 4'd4, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 1);
    check_op("slt_pos", 4'd4, 32'h00000001, 32'hFFFFFFFF, 5'd0, 32'h00000000, 1);
    check_op("sll", 4'd5, 32'h0, 32'h00000001, 5'd31, 32'h80000000, 1);
    check_op("srl", 4'd6, 32'h0, 32'h80000000, 5'd4, 32'h08000000, 1);
    check_op("sra", 4'd7, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 1);
    check_op("rsvd12", 4'd12, 32'h12345678, 32'h9ABCDEF0, 5'd1, 32'h0, 1);

    // Result holds between pulses; out_valid is a single pulse
    check_op("sub", 4'd3, 32'h00000010, 32'h00000003, 5'd0, 32'h0000000D, 1);
    repeat (3) @(posedge clk);
    #1;
    check("hold/result", result, 32'h0000000D);
    check("hold/out_valid", out_valid, 1'b0);

    // MULTU full-scale: busy for 32 cycles, result at edge 33
    do_op(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, res, lat, rl);
    check("mul_max/res", res, 32'h00000001);
    check("mul_max/lat", lat, 33);
    check("mul_max/rdy_low", rl, 32);
    check_op("mul_max/mfhi", 4'd10, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFE, 1);
    check_op("mul_max/mflo", 4'd11, 32'h0, 32'h0, 5'd0, 32'h00000001, 1);
    check_op("rsvd15", 4'd15, 32'h1, 32'h1, 5'd0, 32'h0, 1);
    check_op("rsvd15/mfhi", 4'd10, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFE, 1);

    check_op("mul_2^32", 4'd8, 32'h00010000, 32'h00010000, 5'd0, 32'h00000000, 33);
    check_op("mul_2^32/mfhi", 4'd10, 32'h0, 32'h0, 5'd0, 32'h00000001, 1);

`ifdef EXEC_UNIT_DIVU_EN
    check_op("div_100_7", 4'd9, 32'd100, 32'd7, 5'd0, 32'd14, 33);
    check_op("div_100_7/mfhi", 4'd10, 32'h0, 32'h0, 5'd0, 32'd2, 1);
    check_op("div_5_0", 4'd9, 32'd5, 32'd0, 5'd0, 32'hFFFFFFFF, 33);
    check_op("div_5_0/mfhi", 4'd10, 32'h0, 32'h0, 5'd0, 32'd5, 1);
    check_op("div_5_0/mflo", 4'd11, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1);
`else
    check_op("divu_rsvd", 4'd9, 32'd100, 32'd7, 5'd0, 32'h0, 1);
    check_op("divu_rsvd/mfhi", 4'd10, 32'h0, 32'h0, 5'd0, 32'h00000001, 1);
    check_op("divu_rsvd/mflo", 4'd11, 32'h0, 32'h0, 5'd0, 32'h00000000, 1);
`endif

    // Reset during a MULTU aborts it with no pulse and clears HI/LO
    @(negedge clk);
    in_valid = 1'b1; op = 4'd8; dataA = 32'd3; dataB = 32'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort/busy_before", busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("abort/out_valid", out_valid, 1'b0);
    check("abort/busy", busy, 1'b0);
    check("abort/in_ready", in_ready, 1'b1);
    check("abort/result", result, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort/ready_after", in_ready, 1'b1);
    saw = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) saw++;
    end
    check("abort/no_pulse", saw, 0);
    check_op("abort/mfhi", 4'd10, 32'h0, 32'h0, 5'd0, 32'h0, 1);
    check_op("abort/mflo", 4'd11, 32'h0, 32'h0, 5'd0, 32'h0, 1);

    // WIDTH=8 multiply
    do_op8(4'd8, 8'hFF, 8'h02, res8, lat);
    check("w8_mul/res", res8, 8'hFE);
    check("w8_mul/lat", lat, 9);
    do_op8(4'd10, 8'h00, 8'h00, res8, lat);
    check("w8_mul/mfhi", res8, 8'h01);
    do_op8(4'd11, 8'h00, 8'h00, res8, lat);
    check("w8_mul/mflo", res8, 8'hFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
